// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM encoding for the register-dump streamer.
package reg_dump_pkg;

  localparam int DUMP_DATA_WIDTH = 8;
  localparam int DUMP_ADDR_WIDTH = 2;
  localparam int DUMP_NUM_REGS   = 4;
  localparam logic [DUMP_DATA_WIDTH-1:0] DUMP_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_READ,
    S_SEND,
    S_CHK,
    S_DONE
  } dump_state_e;

endpackage

// File: rtl/reg_dump_unit.sv
// Streams header, R0..R(N-1), XOR checksum; 2*NUM_REGS+3 cycles start-to-done with no stalls.
// Backpressure: tx byte and valid hold while tx_ready is low; writeback held off via hold_req.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int                    DATA_WIDTH = DUMP_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DUMP_ADDR_WIDTH,
  parameter int                    NUM_REGS   = DUMP_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] HEADER     = DUMP_HEADER
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_hold_req,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_data_q, w_data_nxt;
  logic [DATA_WIDTH-1:0] r_checksum, w_chk_nxt;
  logic                  w_hs;

  assign w_hs = o_tx_valid & i_tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data_q;
    w_chk_nxt   = r_checksum;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_HEADER;
          w_idx_nxt   = '0;
          w_chk_nxt   = '0;
        end
      end
      S_HEADER: if (w_hs) w_state_nxt = S_READ;
      S_READ: begin
        // Register is snapshotted here, one cycle ahead of its byte going out.
        w_data_nxt  = i_rd_data;
        w_chk_nxt   = r_checksum ^ i_rd_data;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_CHK;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_READ;
          end
        end
      end
      S_CHK:   if (w_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_data_q   <= '0;
      r_checksum <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_data_q   <= w_data_nxt;
      r_checksum <= w_chk_nxt;
    end
  end

  // All outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (r_state)
      S_HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HEADER;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = r_data_q;
      end
      S_CHK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = r_checksum;
      end
      default: ;
    endcase
  end

  assign o_rd_addr  = r_idx;
  assign o_hold_req = (r_state == S_HEADER) || (r_state == S_READ) ||
                      (r_state == S_SEND)   || (r_state == S_CHK);
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboarded bench: stimulus pushes expected frames, a negedge monitor pops on each accepted byte / done.
module tb_reg_dump_unit;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       hold_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  logic [7:0] regs [4];

  typedef struct {
    logic       is_done;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic prev_stall;
  logic [7:0] prev_dat;

  reg_dump_unit dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_start    (start),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_hold_req (hold_req),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame: header, each register value, XOR of the register values, then done.
  task automatic push_frame(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
    exp_t e;
    logic [7:0] vals [4];
    vals[0] = r0; vals[1] = r1; vals[2] = r2; vals[3] = r3;
    e.is_done = 1'b0; e.dat = 8'hA5;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      e.dat = vals[i];
      exp_q.push_back(e);
    end
    e.dat = r0 ^ r1 ^ r2 ^ r3;
    exp_q.push_back(e);
    e.is_done = 1'b1; e.dat = 8'h00;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, tx_valid}, 32'd1);
        chk("stall_data_held", {24'd0, tx_data}, {24'd0, prev_dat});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte_is_not_done", 32'd0, {31'd0, e.is_done});
          chk("tx_byte", {24'd0, tx_data}, {24'd0, e.dat});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_expected", 32'd1, {31'd0, e.is_done});
        end
      end
    end
    prev_stall = reset_n && tx_valid && !tx_ready;
    prev_dat   = tx_data;
  end

  // mode: 0 ready=1, 1 stall 3 cycles on byte 22, 2 random ready,
  //       3 write R3=FF during SEND of R0, 4 spurious starts, 5 reset during SEND of R2
  task automatic run_frame(input int mode, output int cyc, output int holds);
    logic [7:0] e3;
    int stall;
    bit stalled;
    stall = 0;
    stalled = 0;
    e3 = (mode == 3) ? 8'hFF : regs[3];
    push_frame(regs[0], regs[1], regs[2], e3);
    @(posedge clk); #1;
    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    holds = 0;
    while (!done && cyc < 300) begin
      if (hold_req) holds++;
      if (mode == 1) begin
        if (!stalled && tx_valid && tx_data == 8'h22) begin
          stall = 3; stalled = 1;
        end
        if (stall > 0) begin
          tx_ready = 1'b0; stall--;
        end else begin
          tx_ready = 1'b1;
        end
      end else if (mode == 2) begin
        tx_ready = 1'($urandom_range(0, 1));
      end
      if (mode == 3 && cyc == 3) regs[3] = 8'hFF;
      if (mode == 4 && cyc == 4) start = 1'b1;
      if (mode == 5 && cyc == 7) begin
        chk("r2_in_send", {24'd0, tx_data}, {24'd0, regs[2]});
        tx_ready = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_mid_hold", {31'd0, hold_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 300) chk("frame_timeout", 32'(cyc), 32'd0);
    if (mode == 4) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("still_idle_busy", {31'd0, busy}, 32'd0);
      chk("still_idle_valid", {31'd0, tx_valid}, 32'd0);
    end
    tx_ready = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    regs[0] = a; regs[1] = b; regs[2] = c; regs[3] = d;
  endtask

  initial begin
    int cyc;
    int holds;
    n_cmp = 0;
    n_bad = 0;
    prev_stall = 1'b0;
    prev_dat = 8'h00;
    reset_n = 1'b0;
    start = 1'b0;
    tx_ready = 1'b0;
    preload(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rd_addr", {30'd0, rd_addr}, 32'd0);
    chk("rst_hold", {31'd0, hold_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);

    preload(8'h11, 8'h22, 8'h33, 8'h44);
    run_frame(0, cyc, holds);
    chk("lat_done_cycle", 32'(cyc), 32'd11);
    chk("lat_hold_cycles", 32'(holds), 32'd10);

    run_frame(1, cyc, holds);
    chk("stall_done_cycle", 32'(cyc), 32'd14);
    chk("stall_hold_cycles", 32'(holds), 32'd13);

    preload(8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(0, cyc, holds);
    chk("zero_done_cycle", 32'(cyc), 32'd11);

    preload(8'h11, 8'h22, 8'h33, 8'h44);
    run_frame(4, cyc, holds);
    chk("spurious_done_cycle", 32'(cyc), 32'd11);
    run_frame(0, cyc, holds);
    chk("second_done_cycle", 32'(cyc), 32'd11);

    run_frame(5, cyc, holds);
    run_frame(0, cyc, holds);
    chk("post_rst_done_cycle", 32'(cyc), 32'd11);

    run_frame(3, cyc, holds);
    chk("write_done_cycle", 32'(cyc), 32'd11);

    for (int f = 0; f < 8; f++) begin
      preload(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run_frame(2, cyc, holds);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
